// File: rtl/shift_serializer_if.sv
// Word-load handshake and serial output bundle for shift_serializer.
interface shift_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] data;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             first;
    logic             last;

    // Producer of words / consumer of the serial stream.
    modport master (
        output load_valid,
        output data,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  first,
        input  last
    );

    // The serializer itself.
    modport slave (
        input  load_valid,
        input  data,
        output load_ready,
        output dout,
        output dout_valid,
        output first,
        output last
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter: WIDTH-bit words go out MSB-first,
// one bit per clock, with first/last framing strobes. A one-entry holding
// buffer allows the next word to be accepted mid-stream so consecutive
// words are emitted without an idle cycle.
module shift_serializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_serializer_if.slave  bus
);
    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q,  sreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   hbuf_q,  hbuf_d;
    logic               hvalid_q, hvalid_d;
    logic               accept;
    logic               at_last;

    // All outputs decode registered state only; data never reaches them combinationally.
    assign bus.load_ready = !hvalid_q;
    assign bus.dout_valid = (state_q == SHIFT);
    assign bus.dout       = sreg_q[WIDTH-1];
    assign bus.first      = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.last       = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    assign accept  = bus.load_valid && !hvalid_q;
    assign at_last = (cnt_q == CNT_LAST);

    // State register with asynchronous clear that discards partial and held words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            hbuf_q   <= '0;
            hvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            hbuf_q   <= hbuf_d;
            hvalid_q <= hvalid_d;
        end
    end

    // Next-state logic: load, shift, refill from buffer or bypass on the last bit.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        hbuf_d   = hbuf_q;
        hvalid_d = hvalid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = bus.data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (!at_last) begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                    if (accept) begin
                        hbuf_d   = bus.data;
                        hvalid_d = 1'b1;
                    end
                end else if (hvalid_q) begin
                    // load_ready is low here, so no accept can collide with the drain.
                    sreg_d   = hbuf_q;
                    hvalid_d = 1'b0;
                    cnt_d    = '0;
                end else if (accept) begin
                    // Word offered during the last bit skips the buffer entirely.
                    sreg_d = bus.data;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
